// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter: opcodes and controller states.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_SUB = 2'b00,
    OP_CMP = 2'b01,
    OP_SHL = 2'b10,
    OP_CHG = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared combinational ALU: subtract, compare, left shift and single-bit toggle,
// with overflow, range-error, even-parity and single-zero-bit flags on the result.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int BITS = 8
) (
  input  op_t             op,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic [BITS-1:0] out,
  output logic            ovf,
  output logic            err,
  output logic            even,
  output logic            single
);

  localparam int SW = $clog2(BITS);

  logic            b_oor;
  logic [SW-1:0]   sh;
  logic [2*BITS-1:0] wide;
  logic [BITS-1:0] one;

  assign b_oor = (32'(b) >= 32'(BITS));
  assign sh    = b[SW-1:0];
  assign wide  = {{BITS{1'b0}}, a} << sh;
  assign one   = {{(BITS-1){1'b0}}, 1'b1};

  always_comb begin
    out = '0;
    ovf = 1'b0;
    err = 1'b0;
    unique case (op)
      OP_SUB: begin
        out = a - b;
        ovf = (a[BITS-1] ^ b[BITS-1]) & (out[BITS-1] ^ a[BITS-1]);
      end
      OP_CMP: begin
        if (a == b)     out = '0;
        else if (a > b) out = one;
        else            out = '1;
      end
      OP_SHL: begin
        // Shift amounts past the word width are rejected rather than wrapped.
        if (b_oor) err = 1'b1;
        else begin
          out = wide[BITS-1:0];
          ovf = |wide[2*BITS-1:BITS];
        end
      end
      OP_CHG: begin
        if (b_oor) err = 1'b1;
        else       out = a ^ (one << sh);
      end
      default: out = '0;
    endcase
  end

  // "single" marks a result with exactly one cleared bit.
  assign even   = ~^out;
  assign single = $onehot(~out);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU; one operation in flight,
// result held until the consumer takes it.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [1:0]           i_valid,
  input  logic [1:0][1:0]      i_op,
  input  logic [1:0][BITS-1:0] i_a,
  input  logic [1:0][BITS-1:0] i_b,
  output logic [1:0]           o_ready,
  output logic                 o_res_valid,
  output logic                 o_res_id,
  output logic [BITS-1:0]      o_res_out,
  output logic                 o_res_ovf,
  output logic                 o_res_err,
  output logic                 o_res_even,
  output logic                 o_res_single,
  input  logic                 i_res_ready,
  output logic [7:0]           o_err_cnt,
  output state_t               o_dbg_state
);

  // Handshake: a request moves on the edge where i_valid[r] && o_ready[r]; a result
  // moves on the edge where o_res_valid && i_res_ready. o_ready never depends on
  // o_ready, and o_res_* stay frozen while o_res_valid waits for i_res_ready.

  state_t          state;
  logic            rr_pref;
  op_t             cap_op;
  logic [BITS-1:0] cap_a;
  logic [BITS-1:0] cap_b;
  logic            cap_id;

  logic            grant_id;
  logic            xfer;

  logic [BITS-1:0] alu_out;
  logic            alu_ovf;
  logic            alu_err;
  logic            alu_even;
  logic            alu_single;

  always_comb begin
    o_ready = 2'b00;
    if (!i_rst && state == ST_IDLE) begin
      unique case (i_valid)
        2'b01:   o_ready = 2'b01;
        2'b10:   o_ready = 2'b10;
        2'b11:   o_ready = rr_pref ? 2'b10 : 2'b01;
        default: o_ready = 2'b00;
      endcase
    end
  end

  assign grant_id    = o_ready[1];
  assign xfer        = |o_ready;
  assign o_dbg_state = state;

  alu_arbiter_alu #(.BITS(BITS)) u_alu (
    .op     (cap_op),
    .a      (cap_a),
    .b      (cap_b),
    .out    (alu_out),
    .ovf    (alu_ovf),
    .err    (alu_err),
    .even   (alu_even),
    .single (alu_single)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      rr_pref      <= 1'b0;
      cap_op       <= OP_SUB;
      cap_a        <= '0;
      cap_b        <= '0;
      cap_id       <= 1'b0;
      o_res_valid  <= 1'b0;
      o_res_id     <= 1'b0;
      o_res_out    <= '0;
      o_res_ovf    <= 1'b0;
      o_res_err    <= 1'b0;
      o_res_even   <= 1'b0;
      o_res_single <= 1'b0;
      o_err_cnt    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (xfer) begin
            cap_op  <= op_t'(i_op[grant_id]);
            cap_a   <= i_a[grant_id];
            cap_b   <= i_b[grant_id];
            cap_id  <= grant_id;
            // The loser of this grant wins the next tie.
            rr_pref <= ~grant_id;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          o_res_out    <= alu_out;
          o_res_ovf    <= alu_ovf;
          o_res_err    <= alu_err;
          o_res_even   <= alu_even;
          o_res_single <= alu_single;
          o_res_id     <= cap_id;
          o_res_valid  <= 1'b1;
          state        <= ST_DONE;
        end
        ST_DONE: begin
          if (i_res_ready) begin
            o_res_valid <= 1'b0;
            if (o_res_err && o_err_cnt != ERR_CNT_MAX) o_err_cnt <= o_err_cnt + 8'd1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, hand sequences for arbitration/stall/reset,
// and a result scoreboard fed by the request drivers.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W = 13;  // {id, out[7:0], ovf, err, even, single}

  logic            clk;
  logic            i_rst;
  logic [1:0]      i_valid;
  logic [1:0][1:0] i_op;
  logic [1:0][7:0] i_a;
  logic [1:0][7:0] i_b;
  logic [1:0]      o_ready;
  logic            o_res_valid;
  logic            o_res_id;
  logic [7:0]      o_res_out;
  logic            o_res_ovf;
  logic            o_res_err;
  logic            o_res_even;
  logic            o_res_single;
  logic            i_res_ready;
  logic [7:0]      o_err_cnt;
  state_t          dbg_state;

  logic [W-1:0] exp_q[$];
  int n_cmp;
  int n_fail;

  alu_arbiter #(.BITS(8)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_op         (i_op),
    .i_a          (i_a),
    .i_b          (i_b),
    .o_ready      (o_ready),
    .o_res_valid  (o_res_valid),
    .o_res_id     (o_res_id),
    .o_res_out    (o_res_out),
    .o_res_ovf    (o_res_ovf),
    .o_res_err    (o_res_err),
    .o_res_even   (o_res_even),
    .o_res_single (o_res_single),
    .i_res_ready  (i_res_ready),
    .o_err_cnt    (o_err_cnt),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    i_rst = 1'b1;
    i_valid = 2'b11;
    @(negedge clk);
    check("ready_in_reset", 32'(o_ready), 32'(2'b00));
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    i_valid = 2'b00;
    exp_q.delete();
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model(input logic id, input logic [1:0] op,
                                         input logic [7:0] a, input logic [7:0] b);
    logic [7:0] o;
    logic v;
    logic e;
    int pc;
    o = 8'h00; v = 1'b0; e = 1'b0; pc = 0;
    case (op)
      2'b00: begin
        o = a - b;
        v = (a[7] != b[7]) && (o[7] != a[7]);
      end
      2'b01: begin
        if (a == b) o = 8'h00;
        else if (a > b) o = 8'h01;
        else o = 8'hFF;
      end
      2'b10: begin
        if (b > 8'd7) e = 1'b1;
        else begin
          o = a << b;
          for (int i = 8 - int'(b); i < 8; i++) if (a[i]) v = 1'b1;
        end
      end
      default: begin
        if (b > 8'd7) e = 1'b1;
        else begin
          o = a;
          o[b[2:0]] = ~o[b[2:0]];
        end
      end
    endcase
    for (int i = 0; i < 8; i++) pc += int'(o[i]);
    return {id, o, v, e, (pc % 2 == 0), (pc == 7)};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!i_rst && o_res_valid && i_res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("result", 32'({o_res_id, o_res_out, o_res_ovf, o_res_err, o_res_even, o_res_single}),
              32'(e));
      end
    end
  end

  // ---------------- drivers ----------------
  // Starts and ends just after a rising edge; returns right after the transfer edge.
  task automatic issue(input int r, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [W-1:0] exp);
    bit got;
    got = 1'b0;
    i_valid = 2'b00;
    i_valid[r] = 1'b1;
    i_op[r] = op;
    i_a[r] = a;
    i_b[r] = b;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (o_ready[r]) begin
        got = 1'b1;
        exp_q.push_back(exp);
      end
      @(posedge clk); #1;
    end
    i_valid = 2'b00;
    if (!got) check("grant_timeout", 32'(0), 32'(1));
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain_left", 32'(exp_q.size()), 32'(0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       ovf;
    logic       err;
    logic       even;
    logic       single;
  } vec_t;

  vec_t vecs[13];

  initial begin
    bit got;
    int gap;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [1:0] rop;
    int rr;

    n_cmp = 0; n_fail = 0;
    i_rst = 1'b0; i_valid = '0; i_op = '0; i_a = '0; i_b = '0; i_res_ready = 1'b1;

    vecs[0]  = '{2'b00, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2'b00, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{2'b00, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{2'b01, 8'h10, 8'h20, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{2'b01, 8'h33, 8'h33, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{2'b01, 8'h90, 8'h10, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{2'b10, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{2'b10, 8'h0F, 8'h04, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{2'b10, 8'h12, 8'h08, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{2'b11, 8'h00, 8'h07, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{2'b11, 8'hFF, 8'h00, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{2'b11, 8'h55, 8'h09, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{2'b10, 8'h3C, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0};

    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check("rst_res_valid", 32'(o_res_valid), 32'(0));
    check("rst_res_out", 32'({o_res_id, o_res_out, o_res_ovf, o_res_err, o_res_even, o_res_single}), 32'(0));
    check("rst_err_cnt", 32'(o_err_cnt), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;

    // Single request: grant, latency and first result.
    i_valid = 2'b01; i_op[0] = 2'b00; i_a[0] = 8'h05; i_b[0] = 8'h03;
    @(negedge clk);
    check("first_ready", 32'(o_ready), 32'(2'b01));
    check("first_valid_early", 32'(o_res_valid), 32'(0));
    exp_q.push_back({1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    i_valid = 2'b00;
    @(negedge clk);
    check("exec_ready", 32'(o_ready), 32'(2'b00));
    check("exec_valid", 32'(o_res_valid), 32'(0));
    @(negedge clk);
    check("done_valid", 32'(o_res_valid), 32'(1));
    @(negedge clk);
    check("after_handoff_valid", 32'(o_res_valid), 32'(0));
    @(posedge clk); #1;
    drain();

    // Both requesting from reset: 0 first, then strict alternation.
    do_reset();
    i_valid = 2'b11;
    i_op[0] = 2'b00; i_a[0] = 8'h00; i_b[0] = 8'h01;
    i_op[1] = 2'b00; i_a[1] = 8'hFF; i_b[1] = 8'h01;
    for (int g = 0; g < 4; g++) begin
      got = 1'b0;
      gap = 0;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        if (o_ready != 2'b00) begin
          got = 1'b1;
          gap = k;
          check("rr_grant", 32'(o_ready), (g % 2 == 0) ? 32'(2'b01) : 32'(2'b10));
          if (o_ready[0]) exp_q.push_back({1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0});
          else            exp_q.push_back({1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1});
        end
        @(posedge clk); #1;
      end
      check("rr_gap", 32'(gap), (g == 0) ? 32'(0) : 32'(2));
    end
    i_valid = 2'b00;
    drain();

    // Vector table through requester 0.
    foreach (vecs[i]) begin
      issue(0, vecs[i].op, vecs[i].a, vecs[i].b,
            {1'b0, vecs[i].out, vecs[i].ovf, vecs[i].err, vecs[i].even, vecs[i].single});
    end
    drain();

    // Consumer stall in DONE with inputs churning.
    i_res_ready = 1'b0;
    issue(0, 2'b00, 8'h80, 8'h01, {1'b0, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1});
    for (int k = 0; k < 6; k++) begin
      i_valid = 2'b11;
      i_a = {8'($urandom), 8'($urandom)};
      i_b = {8'($urandom), 8'($urandom)};
      i_op = {2'($urandom), 2'($urandom)};
      @(negedge clk);
      check("stall_ready", 32'(o_ready), 32'(2'b00));
      if (k >= 1) begin
        check("stall_valid", 32'(o_res_valid), 32'(1));
        check("stall_out", 32'({o_res_id, o_res_out, o_res_ovf, o_res_single}), 32'({1'b0, 8'h7F, 1'b1, 1'b1}));
      end
      @(posedge clk); #1;
    end
    i_valid = 2'b00;
    i_res_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_hold_valid", 32'(o_res_valid), 32'(0));
    check("idle_hold_out", 32'(o_res_out), 32'(8'h7F));
    @(posedge clk); #1;
    drain();

    // Random traffic against the model.
    for (int n = 0; n < 20; n++) begin
      rr = $urandom_range(0, 1);
      rop = 2'($urandom_range(0, 3));
      ra = 8'($urandom);
      rb = 8'($urandom_range(0, 11));
      issue(rr, rop, ra, rb, model(rr[0], rop, ra, rb));
    end
    drain();

    // Reset while an operation is in EXEC.
    do_reset();
    issue(0, 2'b10, 8'h01, 8'h09, model(1'b0, 2'b10, 8'h01, 8'h09));
    drain();
    @(negedge clk);
    check("err_cnt_one", 32'(o_err_cnt), 32'(1));
    @(posedge clk); #1;
    i_valid = 2'b01; i_op[0] = 2'b00; i_a[0] = 8'h11; i_b[0] = 8'h01;
    @(negedge clk);
    check("pre_rst_ready", 32'(o_ready), 32'(2'b01));
    @(posedge clk); #1;
    i_valid = 2'b00;
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    @(negedge clk);
    check("rst_exec_valid", 32'(o_res_valid), 32'(0));
    check("rst_exec_err_cnt", 32'(o_err_cnt), 32'(0));
    check("rst_exec_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    check("rst_exec_no_result", 32'(o_res_valid), 32'(0));
    @(posedge clk); #1;
    issue(1, 2'b00, 8'h22, 8'h02, {1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0});
    drain();

    // Lone requester 1 held valid: granted every third cycle.
    i_valid = 2'b10; i_op[1] = 2'b00; i_a[1] = 8'h10; i_b[1] = 8'h01;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("lone_ready", 32'(o_ready), (k % 3 == 0) ? 32'(2'b10) : 32'(2'b00));
      if (o_ready[1]) exp_q.push_back(model(1'b1, 2'b00, i_a[1], 8'h01));
      @(posedge clk); #1;
      if (k % 3 == 0) i_a[1] = i_a[1] + 8'h11;
    end
    i_valid = 2'b00;
    drain();

    // Error counter saturation.
    for (int n = 0; n < 260; n++) begin
      rop = 2'($urandom_range(2, 3));
      rb = 8'($urandom_range(8, 255));
      ra = 8'($urandom);
      issue(0, rop, ra, rb, model(1'b0, rop, ra, rb));
      if (n == 9) begin
        drain();
        @(negedge clk);
        check("err_cnt_10", 32'(o_err_cnt), 32'(10));
        @(posedge clk); #1;
      end
    end
    drain();
    @(negedge clk);
    check("err_cnt_sat", 32'(o_err_cnt), 32'(255));

    check("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: BITS, 8, operand/result width passed to the shared ALU.
REQ-002 SHALL have port: i_clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: i_rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: i_valid  in  2  per-requester request valid, bit r = requester r.
REQ-005 SHALL have port: i_op  in  2x2  per-requester opcode (00 sub, 01 cmp, 10 shift, 11 bit-change).
REQ-006 SHALL have port: i_a  in  2xBITS  per-requester operand A.
REQ-007 SHALL have port: i_b  in  2xBITS  per-requester operand B.
REQ-008 SHALL have port: o_ready  out  2  per-requester accept strobe, at most one bit high.
REQ-009 SHALL have port: o_res_valid  out  1  result available.
REQ-010 SHALL have port: o_res_id  out  1  requester index owning the result.
REQ-011 SHALL have ports: o_res_out (BITS), o_res_ovf, o_res_err, o_res_even, o_res_single  out  registered copies of the shared ALU outputs.
REQ-012 SHALL have port: i_res_ready  in  1  consumer accepts result.
REQ-013 SHALL have port: o_err_cnt  out  8  saturating count of delivered results with o_res_err=1.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-015 IDLE: o_ready combinational; if exactly one i_valid bit high, that requester is granted; if both high, the requester not granted last wins (round-robin).
REQ-016 Request transfer occurs on the edge where i_valid[r] and o_ready[r] are both 1; op, a, b and r are captured into internal registers; next state EXEC.
REQ-017 o_ready SHALL be 2'b00 in EXEC and DONE and in IDLE when i_valid=2'b00.
REQ-018 EXEC: the single shared ALU instance is driven only from the captured registers; its outputs are registered into o_res_*, o_res_id=captured r, o_res_valid=1; next state DONE.
REQ-019 DONE: all o_res_* held stable while i_res_ready=0; on edge with i_res_ready=1, o_res_valid clears and the state returns to IDLE.
REQ-020 Latency: result valid exactly 2 edges after transfer; minimum 3 cycles per operation (no overlap).
REQ-021 Round-robin pointer SHALL update on each transfer to the granted index; a lone requester is granted back-to-back.
REQ-022 Changes on i_valid/i_op/i_a/i_b outside IDLE SHALL have no effect on the in-flight operation.
REQ-023 o_err_cnt SHALL increment by 1 when a result with o_res_err=1 is handed off (DONE and i_res_ready), saturating at 255.
REQ-024 o_res_* SHALL hold last-delivered values in IDLE; o_res_valid=0 there.

Reset
REQ-025 On i_rst=1 at an edge: state IDLE, round-robin pointer favours requester 0, o_res_valid=0, o_res_id=0, o_res_out=0, o_res_ovf/err/even/single=0, o_err_cnt=0, captured registers=0.
REQ-026 Reset in EXEC or DONE SHALL discard the in-flight operation with no result delivered.
REQ-027 o_ready SHALL be 2'b00 while i_rst=1.

Structure
REQ-028 A shared package SHALL hold the opcode enum (OP_SUB, OP_CMP, OP_SHL, OP_CHG) and the FSM state enum.
REQ-029 The existing ALU SHALL be the sole sub-module, instantiated once with BITS passed through; no second ALU instance.

Verification
REQ-030 Reset, then i_valid=01, op=00, a=0x05, b=0x03, i_res_ready=1 -> o_ready=01 for one cycle, o_res_valid 2 edges later, o_res_out=0x02, id=0, even=0, single=0.
REQ-031 Both valid after reset, op=00, req0 a=0x00 b=0x01, req1 a=0xFF b=0x01 -> req0 served first (out=0xFF, even=1), then req1 (out=0xFE, single=1, id=1).
REQ-032 Hold i_res_ready=0 for 5 cycles in DONE while changing i_a/i_b -> o_res_* unchanged, o_ready=00, delivery on first i_res_ready=1.
REQ-033 Assert i_rst during EXEC -> next cycle IDLE, o_res_valid=0, o_err_cnt=0, following request served normally.
REQ-034 Issue 260 operations producing o_res_err=1 (op=10 or 11 with out-of-range b) -> o_err_cnt ends at 255.
REQ-035 Requester 1 alone valid continuously for 3 operations -> granted every 3rd cycle, o_res_id=1 each time.
